bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential double-dabble converter that consumes the n-bit result and sign information produced by the adder/subtractor stage and turns it into packed BCD digits for the display/readout stage. Conversion is accepted with a start/busy handshake, runs one shift-and-adjust iteration per clock, and holds the finished digits and sign stable until the next conversion completes.

## Interface
- `n`, 8: width of the binary input.
- `DIGITS`, 3: number of BCD output digits. Must be ≥ ceil(n·log10 2); with fewer digits the upper digits are silently truncated.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a conversion; sampled only when `busy`=0.
- `din` input n: binary value from the adder/subtractor `s` output.
- `signed_in` input 1: 1 = treat `din` as two's complement.
- `busy` output 1: conversion in progress or done cycle pending.
- `done` output 1: one-cycle pulse, result valid.
- `bcd` output 4·DIGITS: packed BCD, digit 0 in bits [3:0].
- `sign` output 1: 1 = result negative.

## Operation
- FSM states:
  - IDLE: `busy`=0. `start`=1 latches the magnitude into the working shift register, clears the working BCD register and the iteration counter, and moves to SHIFT.
  - SHIFT: each cycle, every working digit ≥5 gets +3, then {bcd_work, mag} shifts left by 1. After exactly n iterations, moves to DONE.
  - DONE: output registers `bcd` and `sign` are loaded, `done`=1; returns to IDLE next cycle.
- Magnitude: if `signed_in`=1 and `din[n-1]`=1, magnitude = (~din + 1) taken as n-bit unsigned, with the pending sign = 1. −2^(n−1) therefore yields 2^(n−1). Otherwise magnitude = `din`, pending sign = 0.
- `bcd`/`sign` change only on entry to DONE. The previous result is held during SHIFT.
- `busy` = (state ≠ IDLE). `start` while busy is ignored and is not queued.
- Iteration counter width = clog2(n+1). No wrap occurs before the n-th iteration.
- Zero input gives `bcd`=0 and `sign`=0. Negative zero cannot occur.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=0, `sign`=0. State = IDLE, counter = 0.
- `start` accepted at edge k → `busy`=1 after edge k.
- SHIFT iterations occur at edges k+1 … k+n. `done`=1 and new `bcd`/`sign` are visible after edge k+n. `busy`=0 after edge k+n+1.
- Latency from accepting edge to `done` is n cycles. Minimum start-to-start spacing is n+1 cycles (start held high restarts in the first IDLE cycle).
- `reset` mid-conversion takes effect at the next edge: back to IDLE, outputs cleared, no `done` pulse. `reset` dominates a simultaneous `start`.

## Configuration
- `BIN_TO_BCD_SIGNED_EN` defined: signed handling as above.
- `BIN_TO_BCD_SIGNED_EN` undefined: `signed_in` is ignored, `din` is always unsigned, `sign` is tied to 0, and the negation logic is removed.
- The port list is identical in both builds.

## Structure
- Shared package `bcd_pkg` holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - `BCD_DIGIT_W`=4;
  - `BCD_ADJ_THRESH`=5;
  - `BCD_ADJ_ADD`=3.
- Sub-module `bcd_digit_adjust`: purely combinational 4-bit in/out. It outputs in+3 if in ≥5, else in. It is instantiated DIGITS times in a generate loop feeding the shift.

## Test plan
- n=8, `din`=8'hFF, `signed_in`=0, `start` at edge k → `done` after edge k+8, `bcd`=12'h255, `sign`=0, `busy` low after edge k+9.
- `din`=8'h80, `signed_in`=1 → `bcd`=12'h128, `sign`=1. `din`=8'hF6, `signed_in`=1 → `bcd`=12'h010, `sign`=1.
- `din`=0 → `bcd`=12'h000, `sign`=0. Then `din`=8'd99 → `bcd`=12'h099, with `bcd` holding 12'h000 until the second `done`.
- Start with 8'd37, then pulse `start` with 8'd200 two cycles later → exactly one `done`, `bcd`=12'h037, second request dropped.
- `reset` asserted 4 cycles into a conversion → next cycle `busy`=0, `bcd`=0, `sign`=0, no `done` pulse. A new start then converts 8'd7 → 12'h007.
- Macro undefined: `din`=8'h80, `signed_in`=1 → `bcd`=12'h128, `sign`=0. Exhaustive sweep of 0..255 against a reference model in both builds.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_e;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Conditional +3 correction.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// Build option: define BIN_TO_BCD_SIGNED_EN to honour signed_in (two's
// complement input, magnitude plus sign). Without it din is always unsigned
// and sign is tied low.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned n      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [n-1:0]                  din,
  input  logic                          signed_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          sign
);

  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = $clog2(n + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(n - 1);

  bcd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [n-1:0]    mag_q, mag_d;
  logic [BcdW-1:0] work_q, work_d;
  logic [BcdW-1:0] work_adj;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic [n-1:0]    mag_in;
  logic            neg_in;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic sign_pend_q, sign_pend_d;
  logic sign_q, sign_d;

  // Negative two's complement inputs are converted as their magnitude.
  always_comb begin
    neg_in = signed_in & din[n-1];
    mag_in = neg_in ? (~din) + n'(1) : din;
  end

  assign sign = sign_q;
`else
  logic unused_signed_in;

  // Unsigned build: input taken as-is, sign never set.
  always_comb begin
    neg_in = 1'b0;
    mag_in = din;
  end

  assign unused_signed_in = signed_in | neg_in;
  assign sign             = 1'b0;
`endif

  // Per-digit +3 correction applied before every shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i(work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(work_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
`ifdef BIN_TO_BCD_SIGNED_EN
    sign_pend_d = sign_pend_q;
    sign_d      = sign_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mag_d   = mag_in;
          work_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_pend_d = neg_in;
`endif
        end
      end
      SHIFT: begin
        work_d = {work_adj[BcdW-2:0], mag_q[n-1]};
        mag_d  = {mag_q[n-2:0], 1'b0};
        cnt_d  = cnt_q + CntW'(1);
        // Last iteration loads the outputs directly so done and data align.
        if (cnt_q == LastIter) begin
          bcd_d   = work_d;
          state_d = DONE;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_d = sign_pend_q;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
`ifdef BIN_TO_BCD_SIGNED_EN
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
`ifdef BIN_TO_BCD_SIGNED_EN
      sign_pend_q <= sign_pend_d;
      sign_q      <= sign_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (n=8, DIGITS=3), valid for both builds of
// BIN_TO_BCD_SIGNED_EN.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  din;
  logic        signed_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        sign;

  int total;
  int bad;

  logic [11:0] exp_last_bcd;
  logic        exp_last_sign;

`ifdef BIN_TO_BCD_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  bin_to_bcd_seq #(
    .n     (8),
    .DIGITS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (din),
    .signed_in(signed_in),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .sign     (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: magnitude then hundreds/tens/units.
  function automatic logic [11:0] ref_bcd(input logic [7:0] d, input logic s);
    int v;
    logic [11:0] r;
    v = int'(d);
    if (SignedEn && s && d[7]) v = 256 - v;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic ref_sign(input logic [7:0] d, input logic s);
    return SignedEn && s && d[7];
  endfunction

  // One full conversion: checks accept, hold of old result, latency, data, busy drop.
  task automatic run_conv(input logic [7:0] d, input logic s, input logic [11:0] eb,
                          input logic es, input string name);
    int lat;
    bit hold_ok;
    @(negedge clk);
    din = d;
    signed_in = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_start got=%b want=1", name, busy);
    end
    lat = 0;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (bcd !== exp_last_bcd || sign !== exp_last_sign) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL %s latency got=%0d want=8", name, lat);
    end
    total++;
    if (!hold_ok) begin
      bad++;
      $display("FAIL %s hold_prev got=changed want=%h/%b", name, exp_last_bcd, exp_last_sign);
    end
    total++;
    if (bcd !== eb) begin
      bad++;
      $display("FAIL %s bcd got=%h want=%h", name, bcd, eb);
    end
    total++;
    if (sign !== es) begin
      bad++;
      $display("FAIL %s sign got=%b want=%b", name, sign, es);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_done_after got=%b%b want=00", name, busy, done);
    end
    exp_last_bcd  = eb;
    exp_last_sign = es;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    din = 8'h00;
    signed_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || sign !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=busy%b done%b bcd%h sign%b want=0 0 000 0",
               busy, done, bcd, sign);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_last_bcd = 12'h000;
    exp_last_sign = 1'b0;
  endtask

  task automatic test_directed();
    run_conv(8'hFF, 1'b0, 12'h255, 1'b0, "ff_unsigned");
    run_conv(8'h80, 1'b1, 12'h128, SignedEn, "80_signed");
    if (SignedEn) run_conv(8'hF6, 1'b1, 12'h010, 1'b1, "f6_signed");
    else          run_conv(8'hF6, 1'b1, 12'h246, 1'b0, "f6_signed");
    run_conv(8'h00, 1'b0, 12'h000, 1'b0, "zero");
    run_conv(8'd99, 1'b0, 12'h099, 1'b0, "ninety_nine");
  endtask

  task automatic test_busy_ignore();
    int dones;
    @(negedge clk);
    din = 8'd37;
    signed_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    din = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL busy_ignore done_count got=%0d want=1", dones);
    end
    total++;
    if (bcd !== 12'h037) begin
      bad++;
      $display("FAIL busy_ignore bcd got=%h want=037", bcd);
    end
    exp_last_bcd = 12'h037;
    exp_last_sign = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    din = 8'hFF;
    signed_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || bcd !== 12'h000 || sign !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got=busy%b bcd%h sign%b want=0 000 0", busy, bcd, sign);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL reset_mid no_done got=pulse want=none");
    end
    exp_last_bcd = 12'h000;
    exp_last_sign = 1'b0;
    run_conv(8'd7, 1'b0, 12'h007, 1'b0, "after_reset");
  endtask

  task automatic test_sweep();
    logic [7:0] d;
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 256; v++) begin
        d = 8'(v);
        run_conv(d, 1'(s), ref_bcd(d, 1'(s)), ref_sign(d, 1'(s)), "sweep");
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
